seg_scan_ctrl: RTL and testbench

//  Time-multiplexes the 4-digit seven-segment display between digits for the calculator top level.

---
 rtl/seg_scan_pkg.sv | 44 ++++
 rtl/seg_scan_ctrl_if.sv | 26 ++
 rtl/scan_prescaler.sv | 42 ++++
 rtl/seg_scan_ctrl.sv | 154 +++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 360 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/seg_scan_pkg.sv
// Shared definitions for the seven-segment scan controller: segment codes (active-low,
// bit order {g,f,e,d,c,b,a}), the code-to-segment decode function and the scan state enum.
package seg_scan_pkg;

  typedef enum logic [0:0] {StBlank, StActive} scan_state_e;

  localparam logic [6:0] SegBlank = 7'b1111111;
  localparam logic [6:0] Seg0     = 7'b1000000;
  localparam logic [6:0] Seg1     = 7'b1111001;
  localparam logic [6:0] Seg2     = 7'b0100100;
  localparam logic [6:0] Seg3     = 7'b0110000;
  localparam logic [6:0] Seg4     = 7'b0011001;
  localparam logic [6:0] Seg5     = 7'b0010010;
  localparam logic [6:0] Seg6     = 7'b0000010;
  localparam logic [6:0] Seg7     = 7'b1111000;
  localparam logic [6:0] Seg8     = 7'b0000000;
  localparam logic [6:0] Seg9     = 7'b0010000;
  localparam logic [6:0] SegDash  = 7'b0111111;
  localparam logic [6:0] SegE     = 7'b0000110;
  localparam logic [6:0] SegR     = 7'b0101111;

  // Codes A..C carry the calculator's "-", "E", "r" glyphs; D..F render dark.
  function automatic logic [6:0] seg_decode(input logic [3:0] code);
    logic [6:0] s;
    case (code)
      4'h0:    s = Seg0;
      4'h1:    s = Seg1;
      4'h2:    s = Seg2;
      4'h3:    s = Seg3;
      4'h4:    s = Seg4;
      4'h5:    s = Seg5;
      4'h6:    s = Seg6;
      4'h7:    s = Seg7;
      4'h8:    s = Seg8;
      4'h9:    s = Seg9;
      4'hA:    s = SegDash;
      4'hB:    s = SegE;
      4'hC:    s = SegR;
      default: s = SegBlank;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Bundle between the calculator core (master) and the display scanner (slave).
//   en, digit_data, dp_in, load     : master -> slave (scan enable, value to stage, stage strobe)
//   an, seg, dp, load_ack, frame_sync : slave -> master (active-low display drive, status pulses)
interface seg_scan_ctrl_if #(
  parameter int unsigned DIGITS = 4
);
  logic                  en;
  logic [4*DIGITS-1:0]   digit_data;
  logic [DIGITS-1:0]     dp_in;
  logic                  load;
  logic [DIGITS-1:0]     an;
  logic [6:0]            seg;
  logic                  dp;
  logic                  load_ack;
  logic                  frame_sync;

  modport master (
    output en, digit_data, dp_in, load,
    input  an, seg, dp, load_ack, frame_sync
  );

  modport slave (
    input  en, digit_data, dp_in, load,
    output an, seg, dp, load_ack, frame_sync
  );
endinterface

// File: rtl/scan_prescaler.sv
// Mod-N counter with count enable and synchronous clear (clear wins).
//   clk, reset : clock, asynchronous active-high reset
//   en, clr    : advance one step / force to zero
//   count      : current value 0..N-1
//   tc         : count is at N-1 (combinational)
module scan_prescaler #(
  parameter int unsigned N = 8,
  parameter int unsigned W = (N > 1) ? $clog2(N) : 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] count,
  output logic         tc
);

  localparam logic [W-1:0] Last = W'(N - 1);

  logic [W-1:0] count_q, count_d;

  assign count = count_q;
  assign tc    = (count_q == Last);

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = tc ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed seven-segment scanner. Each digit slot is DIV cycles: BLANK_CYC dark cycles
// (anti-ghosting) then the digit. Loaded values are staged and copied to the shadow only at
// frame boundaries, so a frame is never torn.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : slave side of seg_scan_ctrl_if (see interface for signal directions)
module seg_scan_ctrl
  import seg_scan_pkg::*;
#(
  parameter int unsigned DIGITS    = 4,
  parameter int unsigned DIV       = 100000,
  parameter int unsigned BLANK_CYC = 16,
  parameter int unsigned LZB       = 1
) (
  input logic            clk,
  input logic            reset,
  seg_scan_ctrl_if.slave bus
);

  localparam int unsigned CntW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned IdxW = $clog2(DIGITS);
  localparam logic [CntW-1:0] BlankCnt = CntW'(BLANK_CYC);

  logic            scan_clr, idx_step, boundary;
  logic [CntW-1:0] cnt;
  logic            cnt_tc;
  logic [IdxW-1:0] idx;
  logic            idx_tc;

  logic [4*DIGITS-1:0] stage_data_q, stage_data_d, shadow_data_q, shadow_data_d;
  logic [DIGITS-1:0]   stage_dp_q, stage_dp_d, shadow_dp_q, shadow_dp_d;
  logic                pending_q, pending_d, load_ack_q, load_ack_d, frame_sync_q;
  scan_state_e         state_q, state_d;
  logic [DIGITS-1:0]   an_q, an_d, lz_blank;
  logic [6:0]          seg_q, seg_d;
  logic                dp_q, dp_d;
  logic [3:0]          cur_code;

  assign scan_clr = ~bus.en;
  assign idx_step = bus.en & cnt_tc;
  assign boundary = idx_step & idx_tc;

  scan_prescaler #(.N(DIV)) u_slot_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (bus.en),
    .clr   (scan_clr),
    .count (cnt),
    .tc    (cnt_tc)
  );

  scan_prescaler #(.N(DIGITS)) u_digit_idx (
    .clk   (clk),
    .reset (reset),
    .en    (idx_step),
    .clr   (scan_clr),
    .count (idx),
    .tc    (idx_tc)
  );

  // Staging / shadow double buffer. A load landing on the boundary bypasses staging.
  always_comb begin
    stage_data_d  = stage_data_q;
    stage_dp_d    = stage_dp_q;
    shadow_data_d = shadow_data_q;
    shadow_dp_d   = shadow_dp_q;
    pending_d     = pending_q;
    load_ack_d    = 1'b0;
    if (bus.load) begin
      stage_data_d = bus.digit_data;
      stage_dp_d   = bus.dp_in;
      pending_d    = 1'b1;
    end
    if (boundary) begin
      if (bus.load) begin
        shadow_data_d = bus.digit_data;
        shadow_dp_d   = bus.dp_in;
        pending_d     = 1'b0;
        load_ack_d    = 1'b1;
      end else if (pending_q) begin
        shadow_data_d = stage_data_q;
        shadow_dp_d   = stage_dp_q;
        pending_d     = 1'b0;
        load_ack_d    = 1'b1;
      end
    end
  end

  // Leading-zero mask: walk down from the top digit while nibble and dp are both zero.
  always_comb begin
    logic zero_run;
    lz_blank = '0;
    zero_run = (LZB != 0);
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_run    = zero_run && (shadow_data_q[4*i +: 4] == 4'h0) && !shadow_dp_q[i];
      lz_blank[i] = zero_run;
    end
  end

  // Scan FSM and registered output values.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StBlank:  if (cnt >= BlankCnt) state_d = StActive;
      StActive: if (cnt < BlankCnt)  state_d = StBlank;
      default:  state_d = StBlank;
    endcase
    if (!bus.en) state_d = StBlank;

    cur_code = shadow_data_q[{idx, 2'b00} +: 4];
    an_d     = '1;
    seg_d    = SegBlank;
    dp_d     = 1'b1;
    if (state_d == StActive) begin
      an_d[idx] = 1'b0;
      seg_d     = lz_blank[idx] ? SegBlank : seg_decode(cur_code);
      dp_d      = ~shadow_dp_q[idx];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stage_data_q  <= '0;
      stage_dp_q    <= '0;
      shadow_data_q <= '0;
      shadow_dp_q   <= '0;
      pending_q     <= 1'b0;
      load_ack_q    <= 1'b0;
      frame_sync_q  <= 1'b0;
      state_q       <= StBlank;
      an_q          <= '1;
      seg_q         <= SegBlank;
      dp_q          <= 1'b1;
    end else begin
      stage_data_q  <= stage_data_d;
      stage_dp_q    <= stage_dp_d;
      shadow_data_q <= shadow_data_d;
      shadow_dp_q   <= shadow_dp_d;
      pending_q     <= pending_d;
      load_ack_q    <= load_ack_d;
      frame_sync_q  <= boundary;
      state_q       <= state_d;
      an_q          <= an_d;
      seg_q         <= seg_d;
      dp_q          <= dp_d;
    end
  end

  assign bus.an         = an_q;
  assign bus.seg        = seg_q;
  assign bus.dp         = dp_q;
  assign bus.load_ack   = load_ack_q;
  assign bus.frame_sync = frame_sync_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl (DIGITS=4, DIV=8, BLANK_CYC=2, LZB=1).
module tb_seg_scan_ctrl;
  localparam int DIGITS = 4;
  localparam int DIV    = 8;
  localparam int BLANK  = 2;
  localparam int FRAME  = DIGITS * DIV;
  localparam logic [6:0] GLYPH [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                        7'h00, 7'h10, 7'h3F, 7'h06, 7'h2F, 7'h7F, 7'h7F, 7'h7F};
  localparam logic [13:0] DARK = {4'hF, 7'h7F, 1'b1, 1'b0, 1'b0};

  logic clk = 1'b0;
  logic reset;
  seg_scan_ctrl_if #(.DIGITS(DIGITS)) bus ();

  seg_scan_ctrl #(.DIGITS(DIGITS), .DIV(DIV), .BLANK_CYC(BLANK), .LZB(1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: k counts enabled cycles since the scan (re)started.
  int          k, prev_k;
  logic [15:0] m_shadow, m_stage;
  logic [3:0]  m_sdp, m_stage_dp;
  logic        m_pending;
  logic [3:0]  exp_an;
  logic [6:0]  exp_seg;
  logic        exp_dp, exp_ack, exp_fs;
  logic [13:0] exp_vec, obs_vec;

  assign obs_vec = {bus.an, bus.seg, bus.dp, bus.load_ack, bus.frame_sync};
  assign exp_vec = {exp_an, exp_seg, exp_dp, exp_ack, exp_fs};

  function automatic logic [6:0] ref_glyph(input int dig);
    logic [15:0] above;
    logic [3:0]  dp_above;
    above    = m_shadow >> (4 * dig);
    dp_above = m_sdp >> dig;
    if (dig > 0 && above == 16'h0 && dp_above == 4'h0) return 7'h7F;
    return GLYPH[m_shadow[4*dig +: 4]];
  endfunction

  task automatic model_reset();
    k = 0; prev_k = 0;
    m_shadow = '0; m_sdp = '0; m_stage = '0; m_stage_dp = '0; m_pending = 1'b0;
    exp_an = 4'hF; exp_seg = 7'h7F; exp_dp = 1'b1; exp_ack = 1'b0; exp_fs = 1'b0;
  endtask

  // Predict what the next clock edge registers, then advance to just after that edge.
  task automatic step();
    int pos, dig;
    bit bnd;
    exp_an = 4'hF; exp_seg = 7'h7F; exp_dp = 1'b1; exp_ack = 1'b0; exp_fs = 1'b0;
    prev_k = k;
    if (!bus.en) begin
      k = 0;
      if (bus.load) begin
        m_stage = bus.digit_data; m_stage_dp = bus.dp_in; m_pending = 1'b1;
      end
    end else begin
      pos = k % DIV;
      dig = (k / DIV) % DIGITS;
      if (pos >= BLANK) begin
        exp_an  = ~(4'b0001 << dig);
        exp_seg = ref_glyph(dig);
        exp_dp  = ~m_sdp[dig];
      end
      bnd    = (k % FRAME) == FRAME - 1;
      exp_fs = bnd;
      if (bnd && bus.load) begin
        m_shadow = bus.digit_data; m_sdp = bus.dp_in; m_pending = 1'b0; exp_ack = 1'b1;
      end else if (bnd && m_pending) begin
        m_shadow = m_stage; m_sdp = m_stage_dp; m_pending = 1'b0; exp_ack = 1'b1;
      end else if (bus.load) begin
        m_stage = bus.digit_data; m_stage_dp = bus.dp_in; m_pending = 1'b1;
      end
      k++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.en = 1'b0; bus.load = 1'b0; bus.digit_data = '0; bus.dp_in = '0;
    model_reset();
    #12;
    tests++;
    if (obs_vec !== DARK) begin
      fails++; $display("FAIL reset_state: got %h want %h", obs_vec, DARK);
    end
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step();
      tests++;
      if (obs_vec !== exp_vec) begin
        fails++; $display("FAIL reset_idle k=%0d: got %h want %h", prev_k, obs_vec, exp_vec);
      end
    end
  endtask

  task automatic test_scan_order();
    int last_fs = -1;
    int fs_cnt  = 0;
    bus.en = 1'b1;
    for (int c = 0; c < 3 * FRAME; c++) begin
      bus.load = (c == 0);
      bus.digit_data = 16'h1234; bus.dp_in = 4'h0;
      step();
      tests++;
      if (obs_vec !== exp_vec) begin
        fails++; $display("FAIL scan_order k=%0d: got %h want %h", prev_k, obs_vec, exp_vec);
      end
      if (bus.frame_sync) begin
        if (last_fs >= 0) begin
          tests++;
          if (c - last_fs !== FRAME) begin
            fails++; $display("FAIL frame_period: got %0d want %0d", c - last_fs, FRAME);
          end
        end
        last_fs = c; fs_cnt++;
      end
      if (c == FRAME + BLANK) begin
        tests++;
        if ({bus.an, bus.seg} !== {4'b1110, 7'b0011001}) begin
          fails++; $display("FAIL digit0_of_1234: got %b want %b", {bus.an, bus.seg}, 11'b11100011001);
        end
      end
    end
    bus.load = 1'b0;
    tests++;
    if (fs_cnt !== 3) begin
      fails++; $display("FAIL frame_sync_count: got %0d want 3", fs_cnt);
    end
  endtask

  task automatic test_load_mid_frame();
    int target = 3 + int'($urandom_range(0, 20));
    int acks = 0;
    for (int c = 0; c < FRAME && (k % FRAME) != target; c++) begin
      step();
      tests++;
      if (obs_vec !== exp_vec) begin
        fails++; $display("FAIL mid_align k=%0d: got %h want %h", prev_k, obs_vec, exp_vec);
      end
    end
    for (int c = 0; c < 2 * FRAME; c++) begin
      bus.load = (c == 0); bus.digit_data = 16'h5678; bus.dp_in = 4'h0;
      step();
      tests++;
      if (obs_vec !== exp_vec) begin
        fails++; $display("FAIL load_mid k=%0d: got %h want %h", prev_k, obs_vec, exp_vec);
      end
      if (bus.load_ack) acks++;
      if (acks == 1 && (prev_k % FRAME) == BLANK) begin
        tests++;
        if (bus.seg !== 7'b0000000) begin
          fails++; $display("FAIL digit0_of_5678: got %b want 0000000", bus.seg);
        end
      end
    end
    bus.load = 1'b0;
    tests++;
    if (acks !== 1) begin
      fails++; $display("FAIL load_mid_acks: got %0d want 1", acks);
    end
  endtask

  task automatic test_multi_load();
    int p1 = int'($urandom_range(0, 10));
    int p2 = int'($urandom_range(12, 28));
    int acks = 0;
    for (int c = 0; c < FRAME && (k % FRAME) != 0; c++) begin
      step();
      tests++;
      if (obs_vec !== exp_vec) begin
        fails++; $display("FAIL multi_align k=%0d: got %h want %h", prev_k, obs_vec, exp_vec);
      end
    end
    // Frame 0: two loads; frame 1: boundary load only; frame 2: mid load then boundary load.
    for (int c = 0; c < 3 * FRAME + 2; c++) begin
      int p = c % FRAME;
      int f = c / FRAME;
      bus.load = 1'b0;
      if (f == 0 && p == p1) begin bus.load = 1'b1; bus.digit_data = 16'h1111; end
      if (f == 0 && p == p2) begin bus.load = 1'b1; bus.digit_data = 16'h2222; end
      if (f == 1 && p == FRAME - 1) begin bus.load = 1'b1; bus.digit_data = 16'h3333; end
      if (f == 2 && p == p1) begin bus.load = 1'b1; bus.digit_data = 16'h4444; end
      if (f == 2 && p == FRAME - 1) begin bus.load = 1'b1; bus.digit_data = 16'h5555; end
      bus.dp_in = 4'h0;
      step();
      tests++;
      if (obs_vec !== exp_vec) begin
        fails++; $display("FAIL multi_load k=%0d: got %h want %h", prev_k, obs_vec, exp_vec);
      end
      if (bus.load_ack) acks++;
      if (f == 1 && p == BLANK) begin
        tests++;
        if (bus.seg !== 7'b0100100) begin
          fails++; $display("FAIL last_load_wins: got %b want 0100100", bus.seg);
        end
      end
    end
    bus.load = 1'b0;
    tests++;
    if (acks !== 3) begin
      fails++; $display("FAIL multi_load_acks: got %0d want 3", acks);
    end
  endtask

  task automatic test_lzb(input logic [3:0] dps);
    logic [11:0] want;
    for (int c = 0; c < FRAME && (k % FRAME) != 0; c++) begin
      step();
      tests++;
      if (obs_vec !== exp_vec) begin
        fails++; $display("FAIL lzb_align k=%0d: got %h want %h", prev_k, obs_vec, exp_vec);
      end
    end
    for (int c = 0; c < 2 * FRAME; c++) begin
      int p = c % FRAME;
      bus.load = (c == 0); bus.digit_data = 16'h0050; bus.dp_in = dps;
      step();
      tests++;
      if (obs_vec !== exp_vec) begin
        fails++; $display("FAIL lzb k=%0d: got %h want %h", prev_k, obs_vec, exp_vec);
      end
      if (c >= FRAME && (p % DIV) == BLANK) begin
        case (p / DIV)
          0:       want = {4'b1110, 7'b1000000, 1'b1};
          1:       want = {4'b1101, 7'b0010010, 1'b1};
          2:       want = dps[2] ? {4'b1011, 7'b1000000, 1'b0} : {4'b1011, 7'h7F, 1'b1};
          default: want = {4'b0111, 7'h7F, 1'b1};
        endcase
        tests++;
        if ({bus.an, bus.seg, bus.dp} !== want) begin
          fails++;
          $display("FAIL lzb_digit%0d dp_in=%b: got %b want %b", p / DIV, dps,
                   {bus.an, bus.seg, bus.dp}, want);
        end
      end
    end
    bus.load = 1'b0;
  endtask

  task automatic test_enable();
    int target = 2 * DIV + BLANK + 2;
    int off = int'($urandom_range(3, 6));
    for (int c = 0; c < FRAME && (k % FRAME) != target; c++) begin
      step();
      tests++;
      if (obs_vec !== exp_vec) begin
        fails++; $display("FAIL en_align k=%0d: got %h want %h", prev_k, obs_vec, exp_vec);
      end
    end
    bus.en = 1'b0;
    for (int c = 0; c < off; c++) begin
      bus.load = (c == 1); bus.digit_data = 16'($urandom); bus.dp_in = 4'($urandom);
      step();
      tests++;
      if (obs_vec !== exp_vec || bus.an !== 4'hF) begin
        fails++; $display("FAIL en_low c=%0d: got %h want %h", c, obs_vec, exp_vec);
      end
    end
    bus.load = 1'b0;
    bus.en = 1'b1;
    for (int c = 0; c < 2 * FRAME; c++) begin
      step();
      tests++;
      if (obs_vec !== exp_vec) begin
        fails++; $display("FAIL en_resume k=%0d: got %h want %h", prev_k, obs_vec, exp_vec);
      end
      if (c <= 2) begin
        tests++;
        if (bus.an !== ((c == 2) ? 4'b1110 : 4'b1111)) begin
          fails++; $display("FAIL en_restart c=%0d: got %b", c, bus.an);
        end
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      bus.en = ($urandom_range(0, 99) < 95);
      bus.load = ($urandom_range(0, 99) < 6);
      bus.digit_data = 16'($urandom);
      bus.dp_in = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      step();
      tests++;
      if (obs_vec !== exp_vec) begin
        fails++; $display("FAIL random k=%0d: got %h want %h", prev_k, obs_vec, exp_vec);
      end
    end
    bus.load = 1'b0;
    bus.en = 1'b1;
  endtask

  task automatic test_async_reset();
    int acks = 0;
    for (int c = 0; c < 2 * FRAME && (k % FRAME) != 5; c++) begin
      step();
      tests++;
      if (obs_vec !== exp_vec) begin
        fails++; $display("FAIL rst_align k=%0d: got %h want %h", prev_k, obs_vec, exp_vec);
      end
    end
    bus.load = 1'b1; bus.digit_data = 16'h9876; bus.dp_in = 4'h0;
    step();
    bus.load = 1'b0;
    for (int c = 0; c < 4; c++) step();
    #2;
    reset = 1'b1;
    #1;
    tests++;
    if (obs_vec !== DARK) begin
      fails++; $display("FAIL async_reset: got %h want %h", obs_vec, DARK);
    end
    #1;
    reset = 1'b0;
    model_reset();
    for (int c = 0; c < FRAME + 4; c++) begin
      step();
      tests++;
      if (obs_vec !== exp_vec) begin
        fails++; $display("FAIL post_reset k=%0d: got %h want %h", prev_k, obs_vec, exp_vec);
      end
      if (bus.load_ack) acks++;
    end
    tests++;
    if (acks !== 0) begin
      fails++; $display("FAIL lost_pending_ack: got %0d want 0", acks);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_scan_order();
    test_load_mid_frame();
    test_multi_load();
    test_lzb(4'b0000);
    test_lzb(4'b0100);
    test_enable();
    test_random();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
